// File: rtl/crossbar_mem_slave.sv
// Memory-backed slave for one crossbar_2m2s port: answers each req with a one-cycle ack after WAIT_CYCLES wait states.
// Optional access counters (wr_cnt/rd_cnt) are enabled by defining CROSSBAR_SLAVE_ACC_CNT_EN.
module crossbar_mem_slave #(
   parameter int DEPTH       = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        slave_req,
   input  logic        slave_cmd,
   input  logic [31:0] slave_addr,
   input  logic [31:0] slave_wdata,
   output logic        slave_ack,
   output logic [31:0] slave_rdata
`ifdef CROSSBAR_SLAVE_ACC_CNT_EN
   ,
   output logic [15:0] wr_cnt,
   output logic [15:0] rd_cnt
`endif
);

   localparam int         IDX_W  = $clog2(DEPTH);
   localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACK,
      S_GAP
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               cmd_q, cmd_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [31:0]        rdata_q;
   logic [31:0]        mem_q [DEPTH];

   logic               access;
   logic               acc_cmd;
   logic [IDX_W-1:0]   acc_idx;
   logic [31:0]        acc_wdata;

   // Upper address bits and the byte offset only alias onto the word index.
   logic               unused_addr;
   assign unused_addr = ^{slave_addr[31:IDX_W+2], slave_addr[1:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         cmd_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cmd_q   <= cmd_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cmd_d     = cmd_q;
      idx_d     = idx_q;
      wdata_d   = wdata_q;
      access    = 1'b0;
      acc_cmd   = cmd_q;
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (slave_req) begin
               cmd_d   = slave_cmd;
               idx_d   = slave_addr[IDX_W+1:2];
               wdata_d = slave_wdata;
               cnt_d   = WAIT_N;
               if (WAIT_N == 4'd0) begin
                  // Zero wait states: the access happens on the accepting edge itself.
                  access    = 1'b1;
                  acc_cmd   = slave_cmd;
                  acc_idx   = slave_addr[IDX_W+1:2];
                  acc_wdata = slave_wdata;
                  state_d   = S_ACK;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               access  = 1'b1;
               state_d = S_ACK;
            end
         end
         S_ACK:   state_d = S_GAP;
         S_GAP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q   <= '{default: '0};
         rdata_q <= '0;
      end else if (access) begin
         if (acc_cmd) begin
            mem_q[acc_idx] <= acc_wdata;
         end else begin
            rdata_q <= mem_q[acc_idx];
         end
      end
   end

   assign slave_ack   = (state_q == S_ACK);
   assign slave_rdata = rdata_q;

`ifdef CROSSBAR_SLAVE_ACC_CNT_EN
   logic [15:0] wr_cnt_q, rd_cnt_q;

   // Saturating counters, stepped on the edge that performs the access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
      end else if (access) begin
         if (acc_cmd) begin
            if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
         end else begin
            if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
         end
      end
   end

   assign wr_cnt = wr_cnt_q;
   assign rd_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_crossbar_mem_slave.sv
// Bench for crossbar_mem_slave: two instances (WAIT_CYCLES=2 and 0) checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_crossbar_mem_slave;

   localparam int DEPTH = 16;
   localparam int NI    = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        req   [NI];
   logic        cmd   [NI];
   logic [31:0] addr  [NI];
   logic [31:0] wdata [NI];
   logic        ack   [NI];
   logic [31:0] rdata [NI];
`ifdef CROSSBAR_SLAVE_ACC_CNT_EN
   logic [15:0] wr_cnt [NI];
   logic [15:0] rd_cnt [NI];
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   crossbar_mem_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut_w2 (
      .clk(clk), .rst(rst),
      .slave_req(req[0]), .slave_cmd(cmd[0]), .slave_addr(addr[0]), .slave_wdata(wdata[0]),
      .slave_ack(ack[0]), .slave_rdata(rdata[0])
`ifdef CROSSBAR_SLAVE_ACC_CNT_EN
      , .wr_cnt(wr_cnt[0]), .rd_cnt(rd_cnt[0])
`endif
   );

   crossbar_mem_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
      .clk(clk), .rst(rst),
      .slave_req(req[1]), .slave_cmd(cmd[1]), .slave_addr(addr[1]), .slave_wdata(wdata[1]),
      .slave_ack(ack[1]), .slave_rdata(rdata[1])
`ifdef CROSSBAR_SLAVE_ACC_CNT_EN
      , .wr_cnt(wr_cnt[1]), .rd_cnt(rd_cnt[1])
`endif
   );

   // Model: each accepted request is an access scheduled WAIT_CYCLES edges later,
   // and the port cannot accept again until WAIT_CYCLES+3 edges after acceptance.
   function automatic int wc(input int i);
      return (i == 0) ? 2 : 0;
   endfunction

   int          edge_n = 0;
   int          ack_edge  [NI];
   int          free_edge [NI];
   logic        pcmd [NI];
   int          pidx [NI];
   logic [31:0] pwd  [NI];
   logic [31:0] mmem [NI][DEPTH];
   logic [31:0] e_rdata [NI];
   logic        e_ack [NI];
   int          e_wr [NI];
   int          e_rd [NI];

   task automatic model_reset(input int i);
      ack_edge[i]  = -1;
      free_edge[i] = 0;
      e_rdata[i]   = '0;
      e_ack[i]     = 1'b0;
      e_wr[i]      = 0;
      e_rd[i]      = 0;
      for (int j = 0; j < DEPTH; j++) mmem[i][j] = '0;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      edge_n++;
      for (int i = 0; i < NI; i++) begin
         if (rst) begin
            model_reset(i);
         end else begin
            if (edge_n >= free_edge[i] && req[i] === 1'b1) begin
               ack_edge[i]  = edge_n + wc(i);
               free_edge[i] = edge_n + wc(i) + 3;
               pcmd[i]      = cmd[i];
               pidx[i]      = int'(addr[i][31:2]) % DEPTH;
               pwd[i]       = wdata[i];
            end
            if (edge_n == ack_edge[i]) begin
               if (pcmd[i]) begin
                  mmem[i][pidx[i]] = pwd[i];
                  if (e_wr[i] < 65535) e_wr[i]++;
               end else begin
                  e_rdata[i] = mmem[i][pidx[i]];
                  if (e_rd[i] < 65535) e_rd[i]++;
               end
            end
            e_ack[i] = (edge_n == ack_edge[i]);
         end
      end
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("ack[%0d]@%0d", i, edge_n), {31'd0, ack[i]}, {31'd0, e_ack[i]});
         chk($sformatf("rdata[%0d]@%0d", i, edge_n), rdata[i], e_rdata[i]);
`ifdef CROSSBAR_SLAVE_ACC_CNT_EN
         chk($sformatf("wr_cnt[%0d]@%0d", i, edge_n), {16'd0, wr_cnt[i]}, 32'(e_wr[i]));
         chk($sformatf("rd_cnt[%0d]@%0d", i, edge_n), {16'd0, rd_cnt[i]}, 32'(e_rd[i]));
`endif
      end
   endtask

   task automatic do_txn(input int i, input logic c, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output int lat);
      req[i] = 1'b1; cmd[i] = c; addr[i] = a; wdata[i] = d;
      lat = 0;
      rd  = '0;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (ack[i] === 1'b1) begin
            lat = k;
            rd  = rdata[i];
            break;
         end
      end
      if (lat == 0) begin
         total++;
         bad++;
         $display("FAIL txn_timeout[%0d]: no ack within 40 cycles, ack required", i);
      end
      req[i] = 1'b0; cmd[i] = 1'b0;
      step();
      step();
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] rd2;
      int          lat;
      int          acks;
      int          first_ack;
      int          second_ack;

      rst = 1'b1;
      for (int i = 0; i < NI; i++) begin
         req[i] = 1'b0; cmd[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
         model_reset(i);
      end
      step();
      step();
      chk("reset_ack", {31'd0, ack[0]}, 32'd0);
      chk("reset_rdata", rdata[0], 32'd0);
      rst = 1'b0;

      // Read right after reset returns zero, latency WAIT_CYCLES+1 sampled cycles.
      do_txn(0, 1'b0, 32'h0000_0030, 32'h0, rd, lat);
      chk("rd_after_reset", rd, 32'h0);
      chk("lat_read_w2", 32'(lat), 32'd3);

      // Write then read back the same word.
      do_txn(0, 1'b1, 32'h0000_0008, 32'hDEADBEEF, rd, lat);
      chk("lat_write_w2", 32'(lat), 32'd3);
      do_txn(0, 1'b0, 32'h0000_0008, 32'h0, rd, lat);
      chk("readback_8", rd, 32'hDEADBEEF);

      // Aliasing modulo DEPTH words, including ignored upper and byte-offset bits.
      do_txn(0, 1'b1, 32'h0000_0004, 32'h0000_0011, rd, lat);
      do_txn(0, 1'b0, 32'h0000_0044, 32'h0, rd, lat);
      chk("alias_44", rd, 32'h0000_0011);
      do_txn(0, 1'b0, 32'hFFFF_FF87, 32'h0, rd, lat);
      chk("alias_high", rd, 32'h0000_0011);

      // req held across ack: one pulse, GAP, next accept only after WAIT_CYCLES+3 cycles.
      req[0] = 1'b1; cmd[0] = 1'b1; addr[0] = 32'h0000_0020; wdata[0] = 32'hA5A5_0001;
      acks = 0; first_ack = 0; second_ack = 0; rd2 = '0;
      for (int k = 1; k <= 9; k++) begin
         step();
         if (k == 1) wdata[0] = 32'h0BAD_0BAD;
         if (ack[0] === 1'b1) begin
            acks++;
            if (first_ack == 0) first_ack = k;
            else begin
               second_ack = k;
               rd2 = rdata[0];
            end
         end
         if (k == 3) cmd[0] = 1'b0;
      end
      req[0] = 1'b0;
      step();
      step();
      chk("held_ack_count", 32'(acks), 32'd2);
      chk("held_first_ack", 32'(first_ack), 32'd3);
      chk("held_period", 32'(second_ack - first_ack), 32'd5);
      chk("held_wdata_ignored", rd2, 32'hA5A5_0001);

      // Reset during the WAIT of a write to 0x0C abandons it.
      req[0] = 1'b1; cmd[0] = 1'b1; addr[0] = 32'h0000_000C; wdata[0] = 32'h5555_AAAA;
      step();
      step();
      rst = 1'b1;
      #1;
      chk("rst_ack_immediate", {31'd0, ack[0]}, 32'd0);
      step();
      rst = 1'b0;
      req[0] = 1'b0; cmd[0] = 1'b0;
      acks = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (ack[0] === 1'b1) acks++;
      end
      chk("rst_no_ack", 32'(acks), 32'd0);
      do_txn(0, 1'b0, 32'h0000_000C, 32'h0, rd, lat);
      chk("rst_mem3_zero", rd, 32'h0);
      chk("rst_idle_lat", 32'(lat), 32'd3);

      // Zero wait states: 3 writes and 2 reads, ack in the cycle after acceptance.
      do_txn(1, 1'b1, 32'h0000_0000, 32'h1000_0001, rd, lat);
      chk("w0_lat_wr", 32'(lat), 32'd1);
      do_txn(1, 1'b1, 32'h0000_0004, 32'h2000_0002, rd, lat);
      do_txn(1, 1'b1, 32'h0000_0008, 32'h3000_0003, rd, lat);
      do_txn(1, 1'b0, 32'h0000_0004, 32'h0, rd, lat);
      chk("w0_lat_rd", 32'(lat), 32'd1);
      chk("w0_rd_4", rd, 32'h2000_0002);
      do_txn(1, 1'b0, 32'h0000_0048, 32'h0, rd, lat);
      chk("w0_rd_alias_8", rd, 32'h3000_0003);
`ifdef CROSSBAR_SLAVE_ACC_CNT_EN
      chk("w0_wr_cnt", {16'd0, wr_cnt[1]}, 32'd3);
      chk("w0_rd_cnt", {16'd0, rd_cnt[1]}, 32'd2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
